// File: rtl/physical_delay_calib.sv
// physical_delay_calib
//   Sweeps all 32 taps of an input delay element. At each tap it waits for
//   the delay to settle, then checks a run of deserialized training words.
//   It picks the longest contiguous run of passing taps and parks the delay
//   at the centre of that run.
//
// Ports
//   i_clk        deserializer CLKDIV clock (single clock domain)
//   i_rst        synchronous, active-high reset
//   i_start      single-cycle request to run a sweep (IDLE/DONE/FAIL only)
//   i_data[5:0]  deserialized word, bit 5 = first bit received
//   o_delay_val  tap value driven to the delay element
//   o_busy       high while a sweep is in progress
//   o_done       level, last sweep found a window
//   o_fail       level, last sweep found no passing tap
//   o_win_start  first tap of the selected window
//   o_win_len    length of the selected window (0..32)
module physical_delay_calib #(
  parameter logic [5:0]  PATTERN       = 6'b111000,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SAMPLE_COUNT  = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [5:0] i_data,
  output logic [4:0] o_delay_val,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_fail,
  output logic [4:0] o_win_start,
  output logic [5:0] o_win_len
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, SAMPLE, EVAL, CENTER, DONE, FAIL
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_COUNT - 1);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [4:0] tap_q;
  logic [5:0] ref_q;
  logic       ok_q;
  logic [4:0] cur_start_q;
  logic [5:0] cur_len_q;
  logic [4:0] best_start_q;
  logic [5:0] best_len_q;

  // Sample-phase combinational view of the reference word and pass flag
  logic [11:0] pat_dbl;
  logic        is_rot;
  logic [5:0]  ref_d;
  logic        ok_d;

  always_comb begin
    pat_dbl = {PATTERN, PATTERN};
    is_rot  = 1'b0;
    for (int unsigned r = 0; r < 6; r++) begin
      if (i_data == pat_dbl[11 - r -: 6]) is_rot = 1'b1;
    end
    if (cnt_q == 8'd0) begin
      ref_d = i_data;
      ok_d  = is_rot;
    end else begin
      ref_d = ref_q;
      ok_d  = ok_q && (i_data == ref_q);
    end
  end

  // Run tracker: a run is closed by a failing tap or by the last tap,
  // and only a strictly longer run displaces the best so ties keep the earliest.
  logic [5:0] ext_len;
  logic [4:0] ext_start;
  logic [5:0] cand_len;
  logic [4:0] cand_start;
  logic       run_close;
  logic       take_best;
  logic [4:0] center_tap;

  always_comb begin
    ext_len    = cur_len_q + 6'd1;
    ext_start  = (cur_len_q == 6'd0) ? tap_q : cur_start_q;
    cand_len   = ok_q ? ext_len   : cur_len_q;
    cand_start = ok_q ? ext_start : cur_start_q;
    run_close  = !ok_q || (tap_q == 5'd31);
    take_best  = run_close && (cand_len > best_len_q);
    center_tap = best_start_q + 5'((best_len_q - 6'd1) >> 1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tap_q        <= '0;
      ref_q        <= '0;
      ok_q         <= 1'b0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      o_delay_val  <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_fail       <= 1'b0;
      o_win_start  <= '0;
      o_win_len    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, FAIL: begin
          if (i_start) begin
            o_done       <= 1'b0;
            o_fail       <= 1'b0;
            o_busy       <= 1'b1;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            tap_q        <= '0;
            o_delay_val  <= '0;
            cnt_q        <= '0;
            state_q      <= LOAD;
          end
        end
        LOAD: begin
          cnt_q   <= '0;
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        SAMPLE: begin
          ref_q <= ref_d;
          ok_q  <= ok_d;
          if (cnt_q == SAMPLE_LAST) begin
            cnt_q   <= '0;
            state_q <= EVAL;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        EVAL: begin
          if (ok_q) begin
            cur_len_q   <= ext_len;
            cur_start_q <= ext_start;
          end else begin
            cur_len_q <= '0;
          end
          if (take_best) begin
            best_len_q   <= cand_len;
            best_start_q <= cand_start;
          end
          if (tap_q == 5'd31) begin
            state_q <= CENTER;
          end else begin
            tap_q       <= tap_q + 5'd1;
            o_delay_val <= tap_q + 5'd1;
            state_q     <= LOAD;
          end
        end
        CENTER: begin
          o_busy <= 1'b0;
          if (best_len_q != 6'd0) begin
            o_delay_val <= center_tap;
            o_win_start <= best_start_q;
            o_win_len   <= best_len_q;
            o_done      <= 1'b1;
            state_q     <= DONE;
          end else begin
            o_delay_val <= '0;
            o_win_start <= '0;
            o_win_len   <= '0;
            o_fail      <= 1'b1;
            state_q     <= FAIL;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/physical_delay_calib.md
PHYSICAL_DELAY_CALIB -- requirements
Module: physical_delay_calib

Interface
REQ-001 The block SHALL have parameter PATTERN, default 6'b111000, giving the 6-bit training word expected from the deserializer.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 8, giving the wait cycles after each tap load (range 1..255).
REQ-003 The block SHALL have parameter SAMPLE_COUNT, default 16, giving the deserialized words checked per tap (range 1..255).
REQ-004 i_clk  input  1  clock, the deserializer CLKDIV clock; all logic is in this single domain.
REQ-005 i_rst  input  1  reset, synchronous and active-high.
REQ-006 i_start  input  1  single-cycle request to run a calibration sweep.
REQ-007 i_data  input  6  deserialized word, bit 5 = first bit received.
REQ-008 o_delay_val  output  5  tap value driven to the input delay element.
REQ-009 o_busy  output  1  high while a sweep is in progress.
REQ-010 o_done  output  1  level; high when the last sweep found a window.
REQ-011 o_fail  output  1  level; high when the last sweep found no passing tap.
REQ-012 o_win_start  output  5  first tap of the selected window.
REQ-013 o_win_len  output  6  length of the selected window, 0..32.

Function
REQ-014 The FSM states SHALL be IDLE, LOAD, SETTLE, SAMPLE, EVAL, CENTER, DONE and FAIL.
REQ-015 In IDLE, DONE or FAIL, a sampled i_start=1 SHALL clear o_done, o_fail and the run trackers, set tap=0 and enter LOAD.
REQ-016 i_start SHALL be ignored in every other state.
REQ-017 o_busy SHALL be high exactly in LOAD, SETTLE, SAMPLE, EVAL and CENTER.
REQ-018 LOAD SHALL last 1 cycle and drive o_delay_val=tap.
REQ-019 SETTLE SHALL last SETTLE_CYCLES cycles; i_data is ignored during this state.
REQ-020 SAMPLE SHALL last SAMPLE_COUNT cycles.
  - The first word is captured as the reference word.
  - The tap passes only if the reference word equals one of the 6 cyclic rotations of PATTERN.
  - Every later word in the same SAMPLE phase must equal the reference word.
REQ-021 EVAL SHALL last 1 cycle and update the contiguous-pass-run tracker.
  - A pass extends the current run.
  - A failing tap, or tap 31, closes the run.
  - A closed run replaces the best run only if it is strictly longer, so the earliest run wins a tie.
REQ-022 From EVAL, tap<31 SHALL increment the tap and return to LOAD; tap=31 SHALL go to CENTER; taps do not wrap.
REQ-023 CENTER SHALL last 1 cycle and then branch.
  - If best length > 0: o_delay_val = best_start + ((best_len-1)>>1), o_win_start/o_win_len = best run, next state DONE (o_done=1).
  - Else: o_delay_val=0, o_win_start=0, o_win_len=0, next state FAIL (o_fail=1).
REQ-024 Sweep latency SHALL be deterministic.
  - o_busy rises on the edge that samples i_start.
  - o_done or o_fail rises 32*(SETTLE_CYCLES+SAMPLE_COUNT+2)+1 edges later: 833 with defaults.
  - o_busy falls on that same edge.
REQ-025 o_delay_val, o_win_start and o_win_len SHALL hold their values in DONE and FAIL until the next accepted i_start.
REQ-026 Window arithmetic SHALL use 6-bit lengths so that a full 32-tap window does not overflow.

Reset
REQ-027 While i_rst=1 at a clock edge, the FSM SHALL go to IDLE and set o_delay_val=0, o_busy=0, o_done=0, o_fail=0, o_win_start=0 and o_win_len=0.
REQ-028 i_rst SHALL take priority over i_start and SHALL abort a sweep in any state with no partial result retained.
REQ-029 The block SHALL NOT start a sweep automatically after reset; it waits for i_start.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
  - All taps pass (i_data constant 6'b111000) -> o_done=1 at edge 833, o_win_start=0, o_win_len=32, o_delay_val=15.
  - Taps 10..20 pass, others feed 6'b101101 -> o_win_start=10, o_win_len=11, o_delay_val=15.
  - Taps 3..6 and 20..27 pass -> o_win_start=20, o_win_len=8, o_delay_val=23; tie case with taps 2..5 and 12..15 -> o_win_start=2, o_delay_val=3.
  - Rotated word 6'b011100 at taps 0..4, and tap 2 toggling to 6'b001110 on its 5th sample -> tap 2 fails, best run = taps 0..1, o_delay_val=0, o_win_len=2.
  - No tap passes -> o_fail=1, o_done=0, o_delay_val=0, o_win_len=0.
  - i_rst pulsed during SAMPLE of tap 17 -> all outputs 0 next cycle, IDLE; i_start asserted during the sweep is ignored (no restart, latency unchanged).
